kernel_window_loader: RTL and testbench
=======================================

// Module: kernel_window_loader
// PURPOSE
//  Downstream of the kernel address generator. Captures pixels returned by data memory as the generator sweeps one
//  kernel column (rows -k..+k). Assembles them into a column, shifts that column into an n x n window register and
//  presents the full window to the WOS sort/weight kernel with a valid/ready handshake. Back-pressures the address side.
// PARAMETERS
//  WORD    8   width of geometry input n (signed, matches address generator)
//  DATA_W  8   pixel width
//  MAX_N   25  max kernel side; odd; window storage MAX_N*MAX_N*DATA_W bits
// PORTS
//  clk         in   1                      clock, rising edge
//  rst         in   1                      async active-low reset
//  n           in   WORD                   kernel side; sampled on line_start
//  line_start  in   1                      pulse: new image line / kernel_newline; clears window
//  pix_valid   in   1                      pixel on pix_in valid this cycle
//  pix_in      in   DATA_W                 pixel value, rows delivered top (r=0) to bottom
//  pix_oob     in   1                      qualifies pix_valid: pixel lies outside image
//  col_done    in   1                      pulse: current column complete; may coincide with last pix_valid
//  win_ready   in   1                      kernel accepts window
//  win_valid   out  1                      window holds n valid columns
//  win_data    out  MAX_N*MAX_N*DATA_W     slot (c,r) at [(c*MAX_N+r)*DATA_W +: DATA_W]; c=0 oldest; unused=0
//  stall       out  1                      = win_valid & ~win_ready; address side must not issue col_done
//  col_count   out  $clog2(MAX_N+1)        columns currently in window, saturates at n_eff
//  err_len     out  1                      sticky: col_done with row count != n_eff
//  err_ovf     out  1                      sticky: col_done accepted while stall high
// BEHAVIOUR
//  Reset: all outputs 0, window/column buffers 0, n_eff=1, state IDLE. Async assert; sync-safe deassert assumed.
//  n_eff on line_start: n<=0 ->1; n>MAX_N ->MAX_N; even ->n-1; else n.
//  FSM: IDLE --line_start--> FILL; FILL --col_done makes col_count==n_eff--> FULL; FULL --win_valid&win_ready--> FILL
//    (slide: col_count stays n_eff, next col_done re-asserts win_valid); any state --line_start--> FILL (cleared).
//  Row counter row (0..n_eff-1) increments per pix_valid; writes colbuf[row]; pixels beyond n_eff dropped, set err_len.
//  col_done: window shifts c -> c-1 (col 0 discarded), colbuf -> col n_eff-1; includes a pixel arriving same cycle.
//    Rows not received this column are 0; err_len set if row count != n_eff. row, colbuf cleared. col_count += 1 sat.
//  Latency: win_valid rises the cycle after the col_done that completes column n_eff; held until win_ready.
//  win_data stable while win_valid high. col_done while stall: column dropped, window unchanged, err_ovf set.
//  pix_valid while stall is legal (collects next column in colbuf).
//  line_start + pix_valid same cycle: clear first, pixel stored as row 0 of new line. line_start + col_done: line_start
//    wins, col_done ignored. win_valid&win_ready same cycle as col_done: handshake completes, then shift (no err).
//  Errors cleared only by reset.
// CONFIGURATION
//  OOB_REPLICATE_EN defined: pix_oob pixel stored as last in-bounds pixel of current column, 0 if none yet.
//  Undefined: pix_oob pixel stored as 0. pix_oob ignored when pix_valid low.
// STRUCTURE
//  Package kernel_window_pkg: FSM state localparams (IDLE/FILL/FULL), DATA_W default, slot-index function,
//    n_eff clamp function (shared with address generator).
//  Sub-module kernel_column_assembler: row counter, colbuf, oob replace, err_len; emits column + col_commit pulse.
// TESTING
//  n=3, line_start, 3 columns of pixels 1..9 with col_done -> win_valid next cycle; slots (0,0)=1,(2,2)=9; col_count=3.
//  Hold win_ready=0, send 4th column -> stall=1, err_ovf=1, win_data unchanged; win_ready=1 -> win_valid drops.
//  n=4 -> n_eff=3; n=40 -> n_eff=25; n=0 -> n_eff=1, each col_done with one pixel asserts win_valid.
//  col_done after 2 of 3 pixels -> row 2 slot 0, err_len=1; 4 pixels -> 4th dropped, err_len=1.
//  pix_oob on rows 0 and 2 values (x,5,x): macro off -> 0,5,0; OOB_REPLICATE_EN -> 0,5,5.
//  rst low mid-FULL -> all outputs 0 immediately; line_start mid-column -> col_count=0, win_valid=0 next cycle.

Source files
------------

// File: rtl/kernel_window_pkg.sv
// Shared types and helpers for the kernel window loader and the kernel address generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package kernel_window_pkg;

  localparam int WORD_DEF   = 8;
  localparam int DATA_W_DEF = 8;
  localparam int MAX_N_DEF  = 25;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } win_state_t;

  // Flat slot index of window column c (0 = oldest), row r.
  function automatic int slot_idx(input int c, input int r, input int max_n);
    return c * max_n + r;
  endfunction

  // Effective kernel side: at least 1, at most max_n, always odd.
  // The address generator uses the same function, so both sides agree on the geometry.
  function automatic int clamp_n_eff(input int n, input int max_n);
    if (n <= 0)          return 1;
    else if (n > max_n)  return max_n;
    else if (n[0] == 1'b0) return n - 1;
    else                 return n;
  endfunction

endpackage

// File: rtl/kernel_column_assembler.sv
// Collects one kernel column of pixels (rows top to bottom) and emits it on col_done.
// Latency: combinational column out; a pixel in the col_done cycle is included in the emitted column.
// Backpressure: none here; the parent decides whether a committed column is kept or dropped.
// Ports: clear (new line), en (accept pixels), n_eff (rows per column), pix_valid/pix_in/pix_oob,
//   col_done -> column (MAX_N*DATA_W, row r at [r*DATA_W +: DATA_W]), col_commit pulse, err_len sticky.
// Optional macro OOB_REPLICATE_EN: out-of-image pixels repeat the last in-bounds pixel of the column.
module kernel_column_assembler #(
  parameter int DATA_W = 8,
  parameter int MAX_N  = 25,
  parameter int CW     = $clog2(MAX_N + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    en,
  input  logic [CW-1:0]           n_eff,
  input  logic                    pix_valid,
  input  logic [DATA_W-1:0]       pix_in,
  input  logic                    pix_oob,
  input  logic                    col_done,
  output logic [MAX_N*DATA_W-1:0] column,
  output logic                    col_commit,
  output logic                    err_len
);

  logic [CW-1:0]           row_q, row_d, row_b, row_w;
  logic [MAX_N*DATA_W-1:0] colbuf_q, colbuf_d, buf_w;
  logic                    err_len_q, err_len_d;
  logic [DATA_W-1:0]       oob_val, pix_val;
  logic                    take, done;

  assign take    = en & pix_valid;
  // line_start wins over col_done: the column being built is discarded by the clear.
  assign done    = en & col_done & ~clear;
  assign pix_val = pix_oob ? oob_val : pix_in;

`ifdef OOB_REPLICATE_EN
  logic [DATA_W-1:0] last_q, last_d, last_b, last_w;

  always_comb begin
    last_b = clear ? '0 : last_q;
    last_w = last_b;
    if (take && !pix_oob && (row_b < n_eff)) last_w = pix_in;
    last_d = done ? '0 : last_w;
  end

  assign oob_val = last_b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_q <= '0;
    else      last_q <= last_d;
  end
`else
  assign oob_val = '0;
`endif

  // Clear is applied before the same-cycle pixel, so that pixel lands in row 0.
  always_comb begin
    row_b     = clear ? '0 : row_q;
    buf_w     = clear ? '0 : colbuf_q;
    row_w     = row_b;
    err_len_d = err_len_q;
    if (take) begin
      if (row_b < n_eff) begin
        buf_w[int'(row_b)*DATA_W +: DATA_W] = pix_val;
        row_w = row_b + 1'b1;
      end else begin
        err_len_d = 1'b1;
      end
    end
    row_d    = row_w;
    colbuf_d = buf_w;
    if (done) begin
      if (row_w != n_eff) err_len_d = 1'b1;
      row_d    = '0;
      colbuf_d = '0;
    end
  end

  assign column     = buf_w;
  assign col_commit = done;
  assign err_len    = err_len_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q     <= '0;
      colbuf_q  <= '0;
      err_len_q <= 1'b0;
    end else begin
      row_q     <= row_d;
      colbuf_q  <= colbuf_d;
      err_len_q <= err_len_d;
    end
  end

endmodule

// File: rtl/kernel_window_loader.sv
// Builds an n x n pixel window from columns returned by data memory and offers it to the sort/weight kernel.
// Latency: win_valid rises the cycle after the col_done that completes column n_eff; held until win_ready.
// Backpressure: stall = win_valid & ~win_ready; a col_done during stall is dropped and flags err_ovf.
// Ports: n/line_start (geometry, new line), pix_valid/pix_in/pix_oob, col_done, win_ready ->
//   win_valid, win_data (slot (c,r) at [(c*MAX_N+r)*DATA_W +: DATA_W], c=0 oldest), stall, col_count,
//   err_len, err_ovf (sticky until reset). Optional macro OOB_REPLICATE_EN (see kernel_column_assembler).
module kernel_window_loader
  import kernel_window_pkg::*;
#(
  parameter int WORD   = WORD_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int MAX_N  = MAX_N_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WORD-1:0]               n,
  input  logic                          line_start,
  input  logic                          pix_valid,
  input  logic [DATA_W-1:0]             pix_in,
  input  logic                          pix_oob,
  input  logic                          col_done,
  input  logic                          win_ready,
  output logic                          win_valid,
  output logic [MAX_N*MAX_N*DATA_W-1:0] win_data,
  output logic                          stall,
  output logic [$clog2(MAX_N+1)-1:0]    col_count,
  output logic                          err_len,
  output logic                          err_ovf
);

  localparam int CW    = $clog2(MAX_N + 1);
  localparam int COL_W = MAX_N * DATA_W;
  localparam int WIN_W = MAX_N * COL_W;

  win_state_t       state_q, state_d;
  logic [CW-1:0]    n_eff_q, n_eff_d;
  logic [CW-1:0]    col_count_q, col_count_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic             win_valid_q, win_valid_d;
  logic             err_ovf_q, err_ovf_d;

  logic             asm_en;
  logic [COL_W-1:0] column;
  logic             col_commit;
  logic             handshake;

  // Pixels are ignored until the first line_start; the line_start cycle itself may carry row 0.
  assign asm_en    = (state_q != IDLE) | line_start;
  assign handshake = win_valid_q & win_ready;
  assign stall     = win_valid_q & ~win_ready;

  kernel_column_assembler #(
    .DATA_W (DATA_W),
    .MAX_N  (MAX_N),
    .CW     (CW)
  ) u_col (
    .clk        (clk),
    .rst        (rst),
    .clear      (line_start),
    .en         (asm_en),
    .n_eff      (n_eff_q),
    .pix_valid  (pix_valid),
    .pix_in     (pix_in),
    .pix_oob    (pix_oob),
    .col_done   (col_done),
    .column     (column),
    .col_commit (col_commit),
    .err_len    (err_len)
  );

  always_comb begin
    state_d     = state_q;
    n_eff_d     = n_eff_q;
    col_count_d = col_count_q;
    win_d       = win_q;
    win_valid_d = win_valid_q;
    err_ovf_d   = err_ovf_q;
    if (line_start) begin
      state_d     = FILL;
      n_eff_d     = CW'(clamp_n_eff(int'($signed(n)), MAX_N));
      col_count_d = '0;
      win_d       = '0;
      win_valid_d = 1'b0;
    end else begin
      // Handshake is resolved first so a column arriving in the same cycle slides in without error.
      if (handshake) begin
        win_valid_d = 1'b0;
        state_d     = FILL;
      end
      if (col_commit) begin
        if (stall) begin
          err_ovf_d = 1'b1;
        end else begin
          // Slide left by one column; the new column enters at n_eff-1, columns beyond stay zero.
          win_d = '0;
          for (int c = 0; c < MAX_N - 1; c++) begin
            if (c < int'(n_eff_q) - 1)
              win_d[slot_idx(c, 0, MAX_N)*DATA_W +: COL_W] = win_q[slot_idx(c + 1, 0, MAX_N)*DATA_W +: COL_W];
          end
          for (int c = 0; c < MAX_N; c++) begin
            if (c == int'(n_eff_q) - 1)
              win_d[slot_idx(c, 0, MAX_N)*DATA_W +: COL_W] = column;
          end
          if (col_count_q < n_eff_q) col_count_d = col_count_q + 1'b1;
          if (col_count_d == n_eff_q) begin
            state_d     = FULL;
            win_valid_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      n_eff_q     <= CW'(1);
      col_count_q <= '0;
      win_q       <= '0;
      win_valid_q <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_eff_q     <= n_eff_d;
      col_count_q <= col_count_d;
      win_q       <= win_d;
      win_valid_q <= win_valid_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  assign win_valid = win_valid_q;
  assign win_data  = win_q;
  assign col_count = col_count_q;
  assign err_ovf   = err_ovf_q;

endmodule

// File: tb/tb_kernel_window_loader.sv
module tb_kernel_window_loader;

  localparam int MAX_N  = 25;
  localparam int DATA_W = 8;
  localparam int CW     = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0] n;
  logic line_start, pix_valid, pix_oob, col_done, win_ready;
  logic [7:0] pix_in;
  logic win_valid, stall, err_len, err_ovf;
  logic [MAX_N*MAX_N*DATA_W-1:0] win_data;
  logic [CW-1:0] col_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  kernel_window_loader dut (
    .clk        (clk),
    .rst        (rst),
    .n          (n),
    .line_start (line_start),
    .pix_valid  (pix_valid),
    .pix_in     (pix_in),
    .pix_oob    (pix_oob),
    .col_done   (col_done),
    .win_ready  (win_ready),
    .win_valid  (win_valid),
    .win_data   (win_data),
    .stall      (stall),
    .col_count  (col_count),
    .err_len    (err_len),
    .err_ovf    (err_ovf)
  );

  function automatic logic [7:0] slot(input int c, input int r);
    return win_data[(c*MAX_N + r)*DATA_W +: DATA_W];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    n = 8'd0; line_start = 1'b0; pix_valid = 1'b0; pix_in = 8'd0;
    pix_oob = 1'b0; col_done = 1'b0; win_ready = 1'b0;
  endtask

  task automatic do_reset();
    clr_in();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic start_line(input logic [7:0] nv);
    n = nv; line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  task automatic pix(input logic [7:0] v, input logic oob, input logic done);
    pix_valid = 1'b1; pix_in = v; pix_oob = oob; col_done = done;
    tick();
    pix_valid = 1'b0; pix_oob = 1'b0; col_done = 1'b0;
  endtask

  task automatic col3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    pix(a, 1'b0, 1'b0);
    pix(b, 1'b0, 1'b0);
    pix(c, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    clr_in();
    rst = 1'b0;
    tick();
    checks++; if (win_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", win_valid); end
    checks++; if (col_count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", col_count); end
    checks++; if (err_len !== 1'b0 || err_ovf !== 1'b0 || stall !== 1'b0) begin
      failures++; $display("FAIL reset_flags got=%b%b%b exp=000", err_len, err_ovf, stall); end
    checks++; if (win_data !== '0) begin failures++; $display("FAIL reset_data got_or=%0b exp=0", |win_data); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_fill();
    do_reset();
    start_line(8'd3);
    col3(8'd1, 8'd2, 8'd3);
    col3(8'd4, 8'd5, 8'd6);
    checks++; if (win_valid !== 1'b0) begin failures++; $display("FAIL fill_early_valid got=%0b exp=0", win_valid); end
    checks++; if (col_count !== 5'd2) begin failures++; $display("FAIL fill_count2 got=%0d exp=2", col_count); end
    col3(8'd7, 8'd8, 8'd9);
    checks++; if (win_valid !== 1'b1) begin failures++; $display("FAIL fill_valid got=%0b exp=1", win_valid); end
    checks++; if (col_count !== 5'd3) begin failures++; $display("FAIL fill_count3 got=%0d exp=3", col_count); end
    checks++; if (slot(0,0) !== 8'd1) begin failures++; $display("FAIL fill_slot00 got=%0d exp=1", slot(0,0)); end
    checks++; if (slot(1,1) !== 8'd5) begin failures++; $display("FAIL fill_slot11 got=%0d exp=5", slot(1,1)); end
    checks++; if (slot(2,2) !== 8'd9) begin failures++; $display("FAIL fill_slot22 got=%0d exp=9", slot(2,2)); end
    checks++; if (slot(3,0) !== 8'd0) begin failures++; $display("FAIL fill_unused got=%0d exp=0", slot(3,0)); end
    checks++; if (stall !== 1'b1 || err_ovf !== 1'b0 || err_len !== 1'b0) begin
      failures++; $display("FAIL fill_flags got stall/ovf/len=%b%b%b exp=100", stall, err_ovf, err_len); end
  endtask

  // Continues from the FULL window left by test_fill.
  task automatic test_stall_ovf();
    col3(8'd10, 8'd11, 8'd12);
    checks++; if (err_ovf !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%0b exp=1", err_ovf); end
    checks++; if (slot(0,0) !== 8'd1 || slot(2,2) !== 8'd9) begin
      failures++; $display("FAIL ovf_hold got=%0d,%0d exp=1,9", slot(0,0), slot(2,2)); end
    win_ready = 1'b1;
    tick();
    win_ready = 1'b0;
    checks++; if (win_valid !== 1'b0 || stall !== 1'b0) begin
      failures++; $display("FAIL ovf_release got valid/stall=%b%b exp=00", win_valid, stall); end
    checks++; if (col_count !== 5'd3) begin failures++; $display("FAIL slide_count got=%0d exp=3", col_count); end
    col3(8'd13, 8'd14, 8'd15);
    checks++; if (win_valid !== 1'b1) begin failures++; $display("FAIL slide_valid got=%0b exp=1", win_valid); end
    checks++; if (slot(0,0) !== 8'd4 || slot(1,0) !== 8'd7 || slot(2,2) !== 8'd15) begin
      failures++; $display("FAIL slide_data got=%0d,%0d,%0d exp=4,7,15", slot(0,0), slot(1,0), slot(2,2)); end
  endtask

  // Handshake and col_done in the same cycle: window accepted, then the new column slides in.
  task automatic test_back_to_back();
    pix(8'd16, 1'b0, 1'b0);
    pix(8'd17, 1'b0, 1'b0);
    win_ready = 1'b1;
    pix(8'd18, 1'b0, 1'b1);
    win_ready = 1'b0;
    checks++; if (win_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid got=%0b exp=1", win_valid); end
    checks++; if (slot(0,0) !== 8'd7 || slot(2,2) !== 8'd18) begin
      failures++; $display("FAIL b2b_data got=%0d,%0d exp=7,18", slot(0,0), slot(2,2)); end
  endtask

  task automatic test_n_clamp();
    do_reset();
    start_line(8'd4);
    col3(8'd1, 8'd2, 8'd3);
    col3(8'd4, 8'd5, 8'd6);
    checks++; if (win_valid !== 1'b0) begin failures++; $display("FAIL n4_early got=%0b exp=0", win_valid); end
    col3(8'd7, 8'd8, 8'd9);
    checks++; if (win_valid !== 1'b1 || col_count !== 5'd3 || err_len !== 1'b0) begin
      failures++; $display("FAIL n4_full got valid/count/len=%b/%0d/%b exp=1/3/0", win_valid, col_count, err_len); end

    do_reset();
    start_line(8'd40);
    for (int c = 0; c < 25; c++) begin
      for (int r = 0; r < 25; r++) pix(8'(c + r + 1), 1'b0, r == 24);
      if (c == 23) begin
        checks++; if (win_valid !== 1'b0 || col_count !== 5'd24) begin
          failures++; $display("FAIL n40_early got valid/count=%b/%0d exp=0/24", win_valid, col_count); end
      end
    end
    checks++; if (win_valid !== 1'b1 || col_count !== 5'd25 || err_len !== 1'b0) begin
      failures++; $display("FAIL n40_full got valid/count/len=%b/%0d/%b exp=1/25/0", win_valid, col_count, err_len); end
    checks++; if (slot(0,0) !== 8'd1 || slot(24,24) !== 8'd49 || slot(3,7) !== 8'd11) begin
      failures++; $display("FAIL n40_data got=%0d,%0d,%0d exp=1,49,11", slot(0,0), slot(24,24), slot(3,7)); end

    do_reset();
    win_ready = 1'b1;
    start_line(8'd0);
    pix(8'h5A, 1'b0, 1'b1);
    checks++; if (win_valid !== 1'b1 || col_count !== 5'd1 || slot(0,0) !== 8'h5A || slot(0,1) !== 8'h00) begin
      failures++; $display("FAIL n0_first got valid/count/s00/s01=%b/%0d/%0h/%0h exp=1/1/5a/0", win_valid, col_count, slot(0,0), slot(0,1)); end
    tick();
    checks++; if (win_valid !== 1'b0) begin failures++; $display("FAIL n0_accept got=%0b exp=0", win_valid); end
    pix(8'h33, 1'b0, 1'b1);
    checks++; if (win_valid !== 1'b1 || slot(0,0) !== 8'h33 || err_len !== 1'b0) begin
      failures++; $display("FAIL n0_second got valid/s00/len=%b/%0h/%b exp=1/33/0", win_valid, slot(0,0), err_len); end

    win_ready = 1'b0;
    start_line(8'hFD);
    pix(8'h21, 1'b0, 1'b1);
    checks++; if (win_valid !== 1'b1 || col_count !== 5'd1) begin
      failures++; $display("FAIL nneg got valid/count=%b/%0d exp=1/1", win_valid, col_count); end
  endtask

  task automatic test_err_len();
    do_reset();
    start_line(8'd3);
    pix(8'd1, 1'b0, 1'b0);
    pix(8'd2, 1'b0, 1'b1);
    checks++; if (err_len !== 1'b1 || col_count !== 5'd1) begin
      failures++; $display("FAIL short_flag got len/count=%b/%0d exp=1/1", err_len, col_count); end
    checks++; if (slot(2,0) !== 8'd1 || slot(2,1) !== 8'd2 || slot(2,2) !== 8'd0) begin
      failures++; $display("FAIL short_data got=%0d,%0d,%0d exp=1,2,0", slot(2,0), slot(2,1), slot(2,2)); end

    do_reset();
    start_line(8'd3);
    pix(8'd1, 1'b0, 1'b0);
    pix(8'd2, 1'b0, 1'b0);
    pix(8'd3, 1'b0, 1'b0);
    checks++; if (err_len !== 1'b0) begin failures++; $display("FAIL long_pre got=%0b exp=0", err_len); end
    pix(8'd4, 1'b0, 1'b1);
    checks++; if (err_len !== 1'b1 || slot(2,0) !== 8'd1 || slot(2,2) !== 8'd3) begin
      failures++; $display("FAIL long_drop got len/s20/s22=%b/%0d/%0d exp=1/1/3", err_len, slot(2,0), slot(2,2)); end
  endtask

  task automatic test_oob();
    logic [7:0] exp2;
`ifdef OOB_REPLICATE_EN
    exp2 = 8'd5;
`else
    exp2 = 8'd0;
`endif
    do_reset();
    start_line(8'd3);
    pix(8'd9, 1'b1, 1'b0);
    pix(8'd5, 1'b0, 1'b0);
    pix(8'd7, 1'b1, 1'b1);
    checks++; if (slot(2,0) !== 8'd0 || slot(2,1) !== 8'd5 || slot(2,2) !== exp2 || err_len !== 1'b0) begin
      failures++; $display("FAIL oob_col got=%0d,%0d,%0d len=%b exp=0,5,%0d len=0", slot(2,0), slot(2,1), slot(2,2), err_len, exp2); end
  endtask

  task automatic test_async_reset();
    do_reset();
    start_line(8'd1);
    pix(8'h11, 1'b0, 1'b1);
    pix(8'h22, 1'b0, 1'b1);
    checks++; if (win_valid !== 1'b1 || err_ovf !== 1'b1) begin
      failures++; $display("FAIL arst_pre got valid/ovf=%b%b exp=11", win_valid, err_ovf); end
    #3;
    rst = 1'b0;
    #1;
    checks++; if (win_valid !== 1'b0 || col_count !== 5'd0 || err_ovf !== 1'b0 || stall !== 1'b0 || win_data !== '0) begin
      failures++; $display("FAIL arst_clear got valid/count/ovf/stall/data=%b/%0d/%b/%b/%b exp=0/0/0/0/0", win_valid, col_count, err_ovf, stall, |win_data); end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_line_start_mid();
    do_reset();
    start_line(8'd3);
    col3(8'd1, 8'd2, 8'd3);
    col3(8'd4, 8'd5, 8'd6);
    col3(8'd7, 8'd8, 8'd9);
    pix(8'h40, 1'b0, 1'b0);
    n = 8'd3; line_start = 1'b1; pix_valid = 1'b1; pix_in = 8'h44;
    tick();
    line_start = 1'b0; pix_valid = 1'b0;
    checks++; if (win_valid !== 1'b0 || col_count !== 5'd0 || win_data !== '0) begin
      failures++; $display("FAIL ls_clear got valid/count/data=%b/%0d/%b exp=0/0/0", win_valid, col_count, |win_data); end
    pix(8'h45, 1'b0, 1'b0);
    pix(8'h46, 1'b0, 1'b1);
    checks++; if (col_count !== 5'd1 || slot(2,0) !== 8'h44 || slot(2,1) !== 8'h45 || slot(2,2) !== 8'h46 || err_len !== 1'b0) begin
      failures++; $display("FAIL ls_newcol got count=%0d col=%0h,%0h,%0h len=%b exp=1 44,45,46 0", col_count, slot(2,0), slot(2,1), slot(2,2), err_len); end
    n = 8'd3; line_start = 1'b1; col_done = 1'b1;
    tick();
    line_start = 1'b0; col_done = 1'b0;
    checks++; if (col_count !== 5'd0 || err_len !== 1'b0) begin
      failures++; $display("FAIL ls_vs_done got count/len=%0d/%b exp=0/0", col_count, err_len); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout after %0d checks", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    clr_in();
    test_reset();
    test_fill();
    test_stall_ovf();
    test_back_to_back();
    test_n_clamp();
    test_err_len();
    test_oob();
    test_async_reset();
    test_line_start_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
